// File: rtl/seg_instruction_fetch.sv
// Instruction fetch stage: PC register, instruction memory with program-load
// port, IF/ID pipeline register and a small IDLE/RUN/HALT control FSM.
module seg_instruction_fetch #(
   parameter int unsigned    LEN         = 32,
   parameter int unsigned    NB_MEM_ADDR = 8,
   parameter logic [LEN-1:0] HALT_WORD   = LEN'(32'hFFFF_FFFF)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_enable,
   input  logic                   i_start,
   input  logic                   i_stall,
   input  logic                   i_jump_flag,
   input  logic [LEN-1:0]         i_PC_dir_jump,
   input  logic                   i_branch_flag,
   input  logic [LEN-1:0]         i_PC_branch,
   input  logic                   i_wr_en,
   input  logic [NB_MEM_ADDR-1:0] i_wr_addr,
   input  logic [LEN-1:0]         i_wr_data,
   output logic [LEN-1:0]         o_PC,
   output logic [LEN-1:0]         o_instruction,
   output logic [LEN-1:0]         o_PC_current,
   output logic                   o_halt
);

   localparam int unsigned DEPTH = 2 ** NB_MEM_ADDR;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t           state;
   logic [LEN-1:0]   pc;
   logic [LEN-1:0]   pc_plus4;
   logic [LEN-1:0]   fetch_word;
   logic [LEN-1:0]   mem [DEPTH];

   // Word-indexed asynchronous read; upper PC bits are ignored so fetch wraps.
   assign fetch_word   = mem[pc[NB_MEM_ADDR+1:2]];
   assign pc_plus4     = pc + LEN'(4);
   assign o_PC_current = pc;

   // Program load: only while not running, and never during reset.
   always_ff @(posedge i_clk) begin
      if (i_rst && i_wr_en && (state != RUN)) begin
         mem[i_wr_addr] <= i_wr_data;
      end
   end

   // Control FSM, PC register and IF/ID register.
   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state         <= IDLE;
         pc            <= '0;
         o_PC          <= '0;
         o_instruction <= '0;
         o_halt        <= 1'b0;
      end else if (i_enable) begin
         case (state)
            IDLE: begin
               pc            <= '0;
               o_PC          <= '0;
               o_instruction <= '0;
               if (i_start) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (i_branch_flag) begin
                  // Branch outranks jump and stall; inject a NOP bubble.
                  pc            <= i_PC_branch;
                  o_PC          <= '0;
                  o_instruction <= '0;
               end else if (i_jump_flag) begin
                  pc            <= i_PC_dir_jump;
                  o_PC          <= '0;
                  o_instruction <= '0;
               end else if (!i_stall) begin
                  o_instruction <= fetch_word;
                  o_PC          <= pc_plus4;
                  if (fetch_word == HALT_WORD) begin
                     // PC stays parked on the halt word's address.
                     state  <= HALT;
                     o_halt <= 1'b1;
                  end else begin
                     pc <= pc_plus4;
                  end
               end
            end
            HALT: begin
               o_instruction <= '0;
               if (i_start) begin
                  state  <= IDLE;
                  o_halt <= 1'b0;
                  pc     <= '0;
                  o_PC   <= '0;
               end
            end
            default: begin
               state         <= IDLE;
               pc            <= '0;
               o_PC          <= '0;
               o_instruction <= '0;
               o_halt        <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seg_instruction_fetch.sv
// Directed bench for seg_instruction_fetch with a queue-based scoreboard.
module tb_seg_instruction_fetch;

   localparam int unsigned LEN = 32;
   localparam int unsigned NB  = 8;
   localparam logic [31:0] HW  = 32'hFFFF_FFFF;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            enable = 1'b0;
   logic            start = 1'b0;
   logic            stall = 1'b0;
   logic            jump = 1'b0;
   logic [LEN-1:0]  jump_pc = '0;
   logic            branch = 1'b0;
   logic [LEN-1:0]  branch_pc = '0;
   logic            wr_en = 1'b0;
   logic [NB-1:0]   wr_addr = '0;
   logic [LEN-1:0]  wr_data = '0;
   logic [LEN-1:0]  o_pc;
   logic [LEN-1:0]  o_ins;
   logic [LEN-1:0]  o_pc_cur;
   logic            o_halt;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      string       nm;
      logic [31:0] pc;
      logic [31:0] opc;
      logic [31:0] ins;
      logic        h;
   } exp_t;

   exp_t q[$];

   seg_instruction_fetch #(.LEN(LEN), .NB_MEM_ADDR(NB), .HALT_WORD(HW)) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_enable      (enable),
      .i_start       (start),
      .i_stall       (stall),
      .i_jump_flag   (jump),
      .i_PC_dir_jump (jump_pc),
      .i_branch_flag (branch),
      .i_PC_branch   (branch_pc),
      .i_wr_en       (wr_en),
      .i_wr_addr     (wr_addr),
      .i_wr_data     (wr_data),
      .o_PC          (o_pc),
      .o_instruction (o_ins),
      .o_PC_current  (o_pc_cur),
      .o_halt        (o_halt)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] fill(input int i);
      return 32'h0A00_0000 | 32'(i);
   endfunction

   task automatic chk(input string nm, input string fld,
                      input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s.%s: got %h expected %h", nm, fld, act, exp);
      end
   endtask

   // Monitor: on each falling edge, compare DUT outputs against the oldest expectation.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk(e.nm, "pc_cur", o_pc_cur, e.pc);
         chk(e.nm, "o_PC",   o_pc,     e.opc);
         chk(e.nm, "instr",  o_ins,    e.ins);
         chk(e.nm, "halt",   {31'b0, o_halt}, {31'b0, e.h});
      end
   end

   // Advance one clock and queue the state expected right after that edge.
   task automatic cyc(input string nm, input logic [31:0] pc, input logic [31:0] opc,
                      input logic [31:0] ins, input logic h);
      @(posedge clk);
      #1;
      q.push_back('{nm, pc, opc, ins, h});
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      wr_en   = 1'b1;
      wr_addr = NB'(a);
      wr_data = d;
      @(posedge clk);
      #1;
      wr_en = 1'b0;
   endtask

   task automatic clr_ctl();
      start  = 1'b0;
      stall  = 1'b0;
      jump   = 1'b0;
      branch = 1'b0;
   endtask

   initial begin
      // Reset
      rst = 1'b0;
      @(posedge clk);
      cyc("reset", 32'h0, 32'h0, 32'h0, 1'b0);
      rst = 1'b1;

      // Program load with enable low (writes still accepted in IDLE)
      for (int i = 0; i < 256; i++) wr(i, fill(i));
      wr(0, 32'h2001_0005);
      wr(1, 32'h2002_0007);
      wr(2, 32'h0022_1820);
      wr(3, HW);

      // Flags ignored in IDLE
      enable = 1'b1;
      branch = 1'b1; branch_pc = 32'h20;
      jump   = 1'b1; jump_pc   = 32'h40;
      cyc("idle_flags", 32'h0, 32'h0, 32'h0, 1'b0);
      clr_ctl();

      // Basic program run to HALT
      start = 1'b1;
      cyc("start", 32'h0, 32'h0, 32'h0, 1'b0);
      start = 1'b0;
      cyc("f0", 32'h4,  32'h4,  32'h2001_0005, 1'b0);
      cyc("f1", 32'h8,  32'h8,  32'h2002_0007, 1'b0);
      cyc("f2", 32'hC,  32'hC,  32'h0022_1820, 1'b0);
      cyc("f3_halt", 32'hC, 32'h10, HW, 1'b1);
      cyc("halt_nop", 32'hC, 32'h10, 32'h0, 1'b1);
      start = 1'b1;
      cyc("halt_to_idle", 32'h0, 32'h0, 32'h0, 1'b0);
      start = 1'b0;

      // Replace halt word so the program keeps running
      wr(3, fill(3));

      // Stall for two cycles at PC=8
      start = 1'b1;
      cyc("start2", 32'h0, 32'h0, 32'h0, 1'b0);
      start = 1'b0;
      cyc("s_f0", 32'h4, 32'h4, 32'h2001_0005, 1'b0);
      cyc("s_f1", 32'h8, 32'h8, 32'h2002_0007, 1'b0);
      stall = 1'b1;
      cyc("stall1", 32'h8, 32'h8, 32'h2002_0007, 1'b0);
      cyc("stall2", 32'h8, 32'h8, 32'h2002_0007, 1'b0);
      stall = 1'b0;
      cyc("resume", 32'hC, 32'hC, 32'h0022_1820, 1'b0);
      cyc("s_f3", 32'h10, 32'h10, fill(3), 1'b0);
      cyc("s_f4", 32'h14, 32'h14, fill(4), 1'b0);
      cyc("s_f5", 32'h18, 32'h18, fill(5), 1'b0);
      // Write attempt while running must be dropped
      wr_en = 1'b1; wr_addr = 8'd5; wr_data = 32'hDEAD_BEEF;
      cyc("run_wr", 32'h1C, 32'h1C, fill(6), 1'b0);
      // Reset mid-run at PC=0x1C, with a write strobe that must also be dropped
      rst = 1'b0; wr_addr = 8'd6; wr_data = 32'hDEAD_BEEF;
      cyc("mid_reset", 32'h0, 32'h0, 32'h0, 1'b0);
      rst = 1'b1; wr_en = 1'b0;

      // Jump at PC=8 to 0x40
      start = 1'b1;
      cyc("start3", 32'h0, 32'h0, 32'h0, 1'b0);
      start = 1'b0;
      cyc("j_f0", 32'h4, 32'h4, 32'h2001_0005, 1'b0);
      cyc("j_f1", 32'h8, 32'h8, 32'h2002_0007, 1'b0);
      jump = 1'b1; jump_pc = 32'h40;
      cyc("jump_nop", 32'h40, 32'h0, 32'h0, 1'b0);
      jump = 1'b0;
      cyc("jump_tgt", 32'h44, 32'h44, fill(16), 1'b0);

      // Readback of words hit by dropped writes
      jump = 1'b1; jump_pc = 32'h14;
      cyc("rb_nop", 32'h14, 32'h0, 32'h0, 1'b0);
      jump = 1'b0;
      cyc("rb_mem5", 32'h18, 32'h18, fill(5), 1'b0);
      cyc("rb_mem6", 32'h1C, 32'h1C, fill(6), 1'b0);

      // Branch + jump + stall together: branch wins
      branch = 1'b1; branch_pc = 32'h20;
      jump   = 1'b1; jump_pc   = 32'h40;
      stall  = 1'b1;
      cyc("bj_nop", 32'h20, 32'h0, 32'h0, 1'b0);
      clr_ctl();
      cyc("bj_tgt", 32'h24, 32'h24, fill(8), 1'b0);

      // Enable low freezes everything
      enable = 1'b0; start = 1'b1; branch = 1'b1; branch_pc = 32'h80;
      cyc("frozen", 32'h24, 32'h24, fill(8), 1'b0);
      enable = 1'b1; clr_ctl();

      // Memory address wrap at 0x3FC
      branch = 1'b1; branch_pc = 32'h3FC;
      cyc("w_nop", 32'h3FC, 32'h0, 32'h0, 1'b0);
      branch = 1'b0;
      cyc("w_last", 32'h400, 32'h400, fill(255), 1'b0);
      cyc("w_wrap", 32'h404, 32'h404, 32'h2001_0005, 1'b0);

      // PC wrap modulo 2^LEN
      branch = 1'b1; branch_pc = 32'hFFFF_FFFC;
      cyc("p_nop", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
      branch = 1'b0;
      cyc("p_wrap", 32'h0, 32'h0, fill(255), 1'b0);

      // Final reset
      rst = 1'b0;
      cyc("final_reset", 32'h0, 32'h0, 32'h0, 1'b0);
      rst = 1'b1;

      // Drain scoreboard with a bounded wait
      for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
      @(negedge clk);
      #1;
      if (q.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seg_instruction_fetch.md
SEG_INSTRUCTION_FETCH -- requirements
Module: seg_instruction_fetch

Interface
REQ-001 Parameter LEN, 32, datapath and PC width.
REQ-002 Parameter NB_MEM_ADDR, 8, instruction memory word-address width (256 words).
REQ-003 Parameter HALT_WORD, 32'hFFFF_FFFF, halt instruction encoding.
REQ-004 i_clk  input  1  clock; all state updates on posedge.
REQ-005 i_rst  input  1  reset, synchronous, active-low.
REQ-006 i_enable  input  1  pipeline enable; 0 freezes PC, IF/ID register and FSM.
REQ-007 i_start  input  1  start execution from IDLE.
REQ-008 i_stall  input  1  hazard stall from decode stage.
REQ-009 i_jump_flag  input  1  jump taken (J/JAL/JR/JALR) from decode stage.
REQ-010 i_PC_dir_jump  input  LEN  jump target byte address.
REQ-011 i_branch_flag  input  1  branch taken from memory stage.
REQ-012 i_PC_branch  input  LEN  branch target byte address.
REQ-013 i_wr_en  input  1  program-load write strobe.
REQ-014 i_wr_addr  input  NB_MEM_ADDR  program-load word address.
REQ-015 i_wr_data  input  LEN  program-load instruction word.
REQ-016 o_PC  output  LEN  IF/ID register: PC+4 of fetched instruction.
REQ-017 o_instruction  output  LEN  IF/ID register: fetched instruction.
REQ-018 o_PC_current  output  LEN  current PC register value.
REQ-019 o_halt  output  1  high while FSM in HALT.

Function
REQ-020 Memory: 2^NB_MEM_ADDR x LEN array; combinational read at index PC[NB_MEM_ADDR+1:2]; upper PC bits ignored (address wraps).
REQ-021 Memory write: on posedge with i_wr_en=1 and FSM in IDLE or HALT, mem[i_wr_addr] <= i_wr_data; i_wr_en ignored in RUN.
REQ-022 FSM states IDLE, RUN, HALT; IDLE->RUN when i_start=1 and i_enable=1; RUN->HALT when an instruction equal to HALT_WORD is latched into IF/ID; HALT->IDLE when i_start=1; no other transitions.
REQ-023 PC update in RUN with i_enable=1, priority: i_branch_flag -> PC<=i_PC_branch; else i_jump_flag -> PC<=i_PC_dir_jump; else i_stall -> PC held; else PC<=PC+4 (modulo 2^LEN).
REQ-024 IF/ID in RUN with i_enable=1: branch or jump -> o_instruction<=0 (NOP), o_PC<=0; else stall -> hold; else o_instruction<=mem word, o_PC<=PC+4.
REQ-025 Branch and jump in same cycle: branch wins, jump ignored.
REQ-026 Stall coincident with branch or jump: stall ignored, redirect applied.
REQ-027 Latency: instruction at PC appears on o_instruction one cycle after PC presented; redirect target fetched the cycle after flag asserted (one NOP bubble).
REQ-028 HALT: PC frozen at address of halt word; o_instruction<=0 each cycle after halt word has been latched for one cycle; o_halt=1.
REQ-029 IDLE: PC, o_PC, o_instruction held at 0; flags ignored.
REQ-030 i_enable=0: all registers and FSM hold regardless of other inputs except memory writes per REQ-021.

Reset
REQ-031 i_rst=0 at posedge: PC=0, o_PC=0, o_instruction=0, FSM=IDLE, o_halt=0; memory contents unchanged.
REQ-032 Reset overrides every other input, including mid-RUN and during i_wr_en.

Verification
REQ-033 Load mem[0..3]=0x20010005,0x20020007,0x00221820,HALT_WORD; i_start -> o_instruction sequence 0x20010005,0x20020007,0x00221820,0xFFFFFFFF with o_PC 4,8,12,16; then o_halt=1, PC=12.
REQ-034 i_stall=1 for 2 cycles while PC=8 -> PC stays 8, o_instruction/o_PC held 2 cycles, then fetch resumes with PC=12.
REQ-035 i_jump_flag=1, i_PC_dir_jump=0x40 at PC=8 -> next cycle o_instruction=0, PC=0x40; following cycle o_instruction=mem[16].
REQ-036 i_branch_flag=1 (target 0x20) and i_jump_flag=1 (target 0x40) same cycle, i_stall=1 -> PC=0x20, one NOP bubble.
REQ-037 i_rst=0 mid-RUN at PC=0x1C -> PC=0, outputs 0, IDLE; i_wr_en during RUN -> memory unchanged on readback.
REQ-038 PC=0x3FC with NB_MEM_ADDR=8, no redirect -> next PC=0x400, fetches mem[0] (wrap).
